// File: rtl/conv_stream_ctrl.sv
// Sequencing controller for the 3x3 convolution datapath.
// Accepts a raster pixel stream, steps the datapath with conv_en, tracks the
// row/column position of every pixel through a tag pipe that mirrors the
// datapath latency, and hands tagged results downstream with valid/ready.
// At end of frame the datapath is flushed with zero pixels before frame_done.
module conv_stream_ctrl #(
    parameter int WORD_SIZE    = 8,
    parameter int ROW_SIZE     = 540,
    parameter int NUM_ROWS     = 480,
    parameter int KERNEL_DIM   = 3,
    parameter int PIPE_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_pixel,
    input  logic                 in_sof,
    output logic                 conv_en,
    output logic [WORD_SIZE-1:0] conv_pixel,
    input  logic [WORD_SIZE-1:0] conv_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_pixel,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 sof_err
);

    localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int DW = $clog2(PIPE_LATENCY + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] COL_MIN    = CW'(KERNEL_DIM - 1);
    localparam logic [RW-1:0] ROW_MIN    = RW'(KERNEL_DIM - 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [DW-1:0]           drain_cnt;

    // Tag pipe: one entry per datapath stage, index PIPE_LATENCY-1 exits.
    logic [PIPE_LATENCY-1:0] vld_p;
    logic [PIPE_LATENCY-1:0] eol_p;
    logic [PIPE_LATENCY-1:0] eof_p;

    logic slot_free;
    logic take;        // pixel enters the datapath this cycle
    logic step;        // datapath advances this cycle
    logic frame_last;  // current position is the final pixel of the frame
    logic tag_vld;
    logic tag_eol;
    logic tag_eof;
    logic capture;

    assign slot_free  = !out_valid || out_ready;
    assign frame_last = (row == ROW_LAST) && (col == COL_LAST);
    assign tag_vld    = (row >= ROW_MIN) && (col >= COL_MIN);
    assign tag_eol    = tag_vld && (col == COL_LAST);
    assign tag_eof    = tag_eol && (row == ROW_LAST);
    assign capture    = step && vld_p[PIPE_LATENCY-1];

    // Next-state, handshake and datapath-enable decode.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        take       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                // Held low while reset is asserted so nothing is accepted.
                in_ready = rst_n;
                take     = rst_n && in_valid && in_sof;
                step     = take;
                if (take) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                in_ready = slot_free;
                take     = in_valid && slot_free;
                step     = take;
                if (take && frame_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                step = (drain_cnt != '0) && slot_free;
                if ((drain_cnt == '0) && !out_valid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        conv_en    = step;
        conv_pixel = take ? in_pixel : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Raster position, drain countdown and sticky mid-frame sof flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            sof_err   <= 1'b0;
        end else begin
            if (take) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (take && frame_last) begin
                drain_cnt <= DRAIN_INIT;
            end else if ((state == S_DRAIN) && step) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            if ((state == S_RUN) && take && in_sof) begin
                sof_err <= 1'b1;
            end
        end
    end

    // Tag pipe shifts in lockstep with the datapath; drain steps insert empty tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            eol_p <= '0;
            eof_p <= '0;
        end else if (step) begin
            vld_p <= (vld_p << 1) | PIPE_LATENCY'(take && tag_vld);
            eol_p <= (eol_p << 1) | PIPE_LATENCY'(take && tag_eol);
            eof_p <= (eof_p << 1) | PIPE_LATENCY'(take && tag_eof);
        end
    end

    // Output register: capture tagged results, release on downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_pixel <= conv_result;
            out_eol   <= eol_p[PIPE_LATENCY-1];
            out_eof   <= eof_p[PIPE_LATENCY-1];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed bench for conv_stream_ctrl on a 5x4 frame with a 4-step datapath
// stand-in (delay line that inverts the pixel).
module tb_conv_stream_ctrl;

    localparam int W    = 8;
    localparam int RS   = 5;
    localparam int NR   = 4;
    localparam int KD   = 3;
    localparam int PL   = 4;
    localparam int NPIX = RS * NR;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_pixel;
    logic         in_sof;
    logic         conv_en;
    logic [W-1:0] conv_pixel;
    logic [W-1:0] conv_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_pixel;
    logic         out_eol;
    logic         out_eof;
    logic         busy;
    logic         frame_done;
    logic         sof_err;

    always #5 clk = ~clk;

    conv_stream_ctrl #(
        .WORD_SIZE   (W),
        .ROW_SIZE    (RS),
        .NUM_ROWS    (NR),
        .KERNEL_DIM  (KD),
        .PIPE_LATENCY(PL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .conv_en    (conv_en),
        .conv_pixel (conv_pixel),
        .conv_result(conv_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .busy       (busy),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    // Datapath stand-in: PL enabled stages, result is the inverted input.
    logic [W-1:0] dl [PL];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PL; i++) dl[i] <= '0;
        end else if (conv_en) begin
            dl[0] <= conv_pixel;
            for (int i = 1; i < PL; i++) dl[i] <= dl[i-1];
        end
    end
    assign conv_result = ~dl[PL-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output and event monitor, sampled on the falling edge.
    logic [9:0] q_out[$];
    int en_cnt   = 0;
    int en_viol  = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) q_out.push_back({out_eol, out_eof, out_pixel});
            if (conv_en) en_cnt <= en_cnt + 1;
            if (conv_en && in_ready && !in_valid) en_viol <= en_viol + 1;
            if (frame_done) done_cnt <= done_cnt + 1;
        end
    end

    // Interior outputs of the 5x4 frame: pixel values r*5+c+1 for r>=2, c>=2.
    int exp_val [6] = '{13, 14, 15, 18, 19, 20};
    bit exp_eol [6] = '{0, 0, 1, 0, 0, 1};
    bit exp_eof [6] = '{0, 0, 0, 0, 0, 1};

    task automatic check_outputs(input string tag, input int base);
        logic [W-1:0] ev;
        for (int i = 0; i < 6; i++) begin
            if (base + i < q_out.size()) begin
                ev = 8'(exp_val[i]);
                check(tag, 32'(q_out[base+i]), 32'({exp_eol[i], exp_eof[i], ~ev}));
            end
        end
    endtask

    task automatic send_frame(input int sof_extra, input bit toggle, input int stall_at);
        bit acc;
        int viol;
        logic [W-1:0] held;
        for (int idx = 0; idx < NPIX; idx++) begin
            if (idx == stall_at) begin
                in_valid = 1'b0;
                for (int t = 0; t < 100 && !out_valid; t++) begin
                    @(posedge clk); #1;
                end
                check("stall_wait_valid", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                held      = out_pixel;
                in_valid  = 1'b1;
                in_pixel  = 8'(idx + 1);
                in_sof    = 1'b0;
                viol      = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (in_ready || conv_en || !out_valid || (out_pixel !== held)) viol++;
                end
                check("stall_hold", 32'(viol), 32'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
            in_valid = 1'b1;
            in_pixel = 8'(idx + 1);
            in_sof   = (idx == 0) || (idx == sof_extra);
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                check("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                in_sof   = 1'b0;
                return;
            end
            in_sof = 1'b0;
            if (toggle) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Waits for frame_done, then steps to the following cycle (back in IDLE).
    task automatic wait_done();
        bit seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            seen = frame_done;
        end
        check("frame_done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        check("frame_done_pulse", 32'(frame_done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({in_ready, conv_en, out_valid, out_eol, out_eof, busy, frame_done, sof_err}), 32'd0);
        check(tag, 32'({conv_pixel, out_pixel}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base, e0, d0, v0, eofs;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);

        // Non-sof pixel in IDLE is dropped without stepping the datapath.
        in_valid = 1'b1;
        in_pixel = 8'd99;
        @(negedge clk);
        check("idle_discard_en", 32'(conv_en), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("idle_discard_busy", 32'(busy), 32'd0);

        // Continuous frame.
        base = q_out.size(); e0 = en_cnt; d0 = done_cnt;
        send_frame(-1, 1'b0, -1);
        check("busy_drain", 32'(busy), 32'd1);
        wait_done();
        check("f1_count", 32'(q_out.size() - base), 32'd6);
        check_outputs("f1_out", base);
        check("f1_en_steps", 32'(en_cnt - e0), 32'(NPIX + PL));
        check("f1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Downstream stall mid-stream.
        base = q_out.size(); e0 = en_cnt;
        send_frame(-1, 1'b0, 17);
        wait_done();
        check("f2_count", 32'(q_out.size() - base), 32'd6);
        check_outputs("f2_out", base);
        check("f2_en_steps", 32'(en_cnt - e0), 32'(NPIX + PL));

        // Bubbled input stream.
        base = q_out.size(); e0 = en_cnt; v0 = en_viol;
        send_frame(-1, 1'b1, -1);
        wait_done();
        check("f3_count", 32'(q_out.size() - base), 32'd6);
        check_outputs("f3_out", base);
        check("f3_en_steps", 32'(en_cnt - e0), 32'(NPIX + PL));
        check("f3_en_no_accept", 32'(en_viol - v0), 32'd0);
        check("sof_err_clean", 32'(sof_err), 32'd0);

        // Stray sof mid-frame.
        base = q_out.size();
        send_frame(7, 1'b0, -1);
        check("sof_err_set", 32'(sof_err), 32'd1);
        wait_done();
        check("sof_err_sticky", 32'(sof_err), 32'd1);
        check("f4_count", 32'(q_out.size() - base), 32'd6);
        check_outputs("f4_out", base);

        // Reset during DRAIN, then a clean frame.
        send_frame(-1, 1'b0, -1);
        @(posedge clk); #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("drain_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = q_out.size(); d0 = done_cnt;
        send_frame(-1, 1'b0, -1);
        wait_done();
        check("f5_count", 32'(q_out.size() - base), 32'd6);
        check_outputs("f5_out", base);
        check("f5_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Two frames back-to-back, second sof right after frame_done.
        base = q_out.size(); d0 = done_cnt;
        send_frame(-1, 1'b0, -1);
        wait_done();
        send_frame(-1, 1'b0, -1);
        wait_done();
        check("b2b_count", 32'(q_out.size() - base), 32'd12);
        check_outputs("b2b_out_a", base);
        check_outputs("b2b_out_b", base + 6);
        eofs = 0;
        for (int i = base; i < q_out.size(); i++) eofs += int'(q_out[i][8]);
        check("b2b_eof_cnt", 32'(eofs), 32'd2);
        check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_stream_ctrl.md
Name: conv_stream_ctrl

Overview:
- Sequencing controller for the 3x3 convolution datapath.
- Takes a raster pixel stream with valid/ready on the upstream side and drives the datapath's clock-enable and input pixel.
- Tracks row/column position and tags each datapath result as a valid interior output, end-of-line or end-of-frame.
- Presents results downstream with valid/ready, flushes the pipeline at end of frame, and pulses frame completion.

Parameters:
- WORD_SIZE, 8, pixel width in bits.
- ROW_SIZE, 540, pixels per image row.
- NUM_ROWS, 480, rows per frame.
- KERNEL_DIM, 3, kernel edge length; interior margin is KERNEL_DIM-1.
- PIPE_LATENCY, 4, number of conv_en steps from pixel presented to its result on conv_result.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  controller accepts pixel this cycle
- in_pixel  in  WORD_SIZE  upstream pixel
- in_sof  in  1  qualifies the first pixel of a frame (sampled with in_valid)
- conv_en  out  1  datapath clock-enable; datapath advances one step when high
- conv_pixel  out  WORD_SIZE  pixel to datapath (in_pixel on accept, 0 during drain)
- conv_result  in  WORD_SIZE  datapath output, aligned PIPE_LATENCY conv_en steps after its input
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_pixel  out  WORD_SIZE  result pixel
- out_eol  out  1  last valid output of an output row
- out_eof  out  1  last valid output of the frame
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse after the final eof output is consumed
- sof_err  out  1  sticky; in_sof seen mid-frame; cleared only by reset

Behaviour:
- Reset (rst_n low, async): state=IDLE; counters=0; tag pipe cleared.
  - Outputs: in_ready=0, conv_en=0, conv_pixel=0, out_valid=0, out_pixel=0, out_eol=0, out_eof=0, busy=0, frame_done=0, sof_err=0.
  - Reset mid-frame abandons all in-flight data; no output is produced for that frame.
- FSM states and transitions:
  - IDLE: in_ready=1. A pixel with in_valid&in_sof is accepted as (r0,c0), then state goes to RUN. in_valid without in_sof is consumed and discarded with conv_en=0.
  - RUN: accepts the remaining pixels of the frame. Accepting (NUM_ROWS-1, ROW_SIZE-1) moves state to DRAIN with drain count=PIPE_LATENCY.
  - DRAIN: in_ready=0. Each conv_en step decrements the count. At zero, and once the output register is empty, state goes to DONE.
  - DONE: frame_done=1 for one cycle, then state goes to IDLE.
- Output slot and stall:
  - slot_free = !out_valid | out_ready.
  - in_ready = slot_free in RUN; in_ready = 1 in IDLE.
  - conv_en = (accept in IDLE-with-sof or RUN) | (DRAIN & count>0 & slot_free).
  - The datapath never advances while a result is held and unconsumed, so nothing is lost under backpressure.
- Counters: col 0..ROW_SIZE-1 wraps to 0 and increments row; row 0..NUM_ROWS-1. Both advance on accept only.
- Tag pipe: PIPE_LATENCY entries of {v, eol, eof}, shifting on conv_en.
  - Entered tag: v = (row>=KERNEL_DIM-1 & col>=KERNEL_DIM-1).
  - eol = v & col==ROW_SIZE-1.
  - eof = eol & row==NUM_ROWS-1.
  - Drain steps insert v=0.
- Output capture: on a conv_en step whose exiting tag has v=1, register out_pixel=conv_result and out_eol/out_eof, and set out_valid=1.
  - Otherwise out_valid clears on handshake (out_valid&out_ready).
  - Capture and handshake in the same cycle: the new result replaces the old one and out_valid stays 1.
- Output frame size: (ROW_SIZE-2)x(NUM_ROWS-2) pixels, in raster order.
- Latency: first valid output appears PIPE_LATENCY conv_en steps after accepting (2,2).
- Simultaneous events: in_sof with in_valid in RUN sets sof_err. The pixel is treated as ordinary data and the frame is not restarted.
- busy=1 in RUN and DRAIN; busy=0 in IDLE and DONE.

Test Plan:
- ROW_SIZE=5, NUM_ROWS=4, PIPE_LATENCY=4, continuous in_valid, out_ready=1, 20 pixels, sof on first -> exactly 6 outputs in order; out_eol on outputs 3 and 6; out_eof on output 6 only; frame_done 1 cycle later; busy falls.
- Same frame with out_ready low for 10 cycles mid-stream -> in_ready=0 and conv_en=0 throughout the stall; out_pixel held stable; all 6 outputs delivered with no duplicates or losses.
- in_valid toggled 1/0 every cycle -> conv_en pulses only on accepts; results identical to the continuous case.
- in_sof asserted on pixel 7 -> sof_err=1 and stays 1; still exactly 6 outputs; frame completes normally.
- rst_n pulsed low during DRAIN -> all outputs read reset values immediately; next sof frame yields exactly 6 outputs.
- Two frames back-to-back, second sof on the cycle after frame_done -> 12 outputs, two eof, two frame_done pulses.
